alu_sequencer: RTL and testbench

Initiator-side controller for the combinational ALU in the single-cycle datapath. Accepts operation requests over a valid/ready handshake, drives the ALU's operand and opcode inputs, and captures the ALU result and zero flag into registers. It iterates multi-bit right shifts as repeated single-bit kRSH passes. It returns the result over a second valid/ready handshake. It sits between the control/issue logic and the ALU, and turns the ALU into a handshaked, multi-cycle-capable functional unit.

---
 rtl/alu_sequencer.sv | 177 +++++++++++++++++
 tb/tb_alu_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Opcode encodings shared with the ALU, followed by the sequencer that wraps
// the combinational ALU in request/response handshakes. The sequencer builds
// multi-bit right shifts by feeding each single-bit kRSH result back into the
// ALU until the requested count is used up.

package definitions;

  localparam logic [3:0] kADD   = 4'd0;
  localparam logic [3:0] kR_XOR = 4'd1;
  localparam logic [3:0] kXOR   = 4'd2;
  localparam logic [3:0] kAND   = 4'd3;
  localparam logic [3:0] kRSH   = 4'd4;
  localparam logic [3:0] SEQ    = 4'd5;
  localparam logic [3:0] SLT    = 4'd6;

endpackage

module alu_sequencer
  import definitions::*;
(
  input  logic       Clk,
  input  logic       Reset,

  input  logic       ReqValid,
  output logic       ReqReady,
  input  logic [3:0] ReqOp,
  input  logic [7:0] ReqA,
  input  logic [7:0] ReqB,
  input  logic [2:0] ReqCount,

  output logic [7:0] AluA,
  output logic [7:0] AluB,
  output logic [3:0] AluOp,
  input  logic [7:0] AluOut,
  input  logic       AluZero,

  output logic       RspValid,
  input  logic       RspReady,
  output logic [7:0] RspData,
  output logic       RspZero,

  output logic       Busy,
  output logic [7:0] OpCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     state_q,    state_d;
  logic [3:0] op_q,       op_d;
  logic [7:0] acc_q,      acc_d;
  logic [7:0] b_q,        b_d;
  logic [2:0] cnt_q,      cnt_d;
  logic [7:0] res_q,      res_d;
  logic       zero_q,     zero_d;
  logic [7:0] op_count_q, op_count_d;

  logic req_is_rsh;
  logic req_no_shift;
  logic exec_is_rsh;
  logic last_shift;
  logic req_fire;
  logic rsp_fire;

  // Decode the conditions that steer the state machine so the transition
  // logic below reads as a direct list of cases.
  always_comb begin
    req_is_rsh   = (ReqOp == kRSH);
    req_no_shift = req_is_rsh && (ReqCount == 3'd0);
    exec_is_rsh  = (op_q == kRSH);
    last_shift   = (cnt_q == 3'd1);
    req_fire     = (state_q == IDLE) && ReqValid;
    rsp_fire     = (state_q == RESP) && RspReady;
  end

  // Next-state and register updates for the accept / execute / respond flow.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    acc_d      = acc_q;
    b_d        = b_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    zero_d     = zero_q;
    op_count_d = op_count_q;

    case (state_q)
      IDLE: begin
        if (req_fire) begin
          op_d  = ReqOp;
          acc_d = ReqA;
          b_d   = ReqB;
          cnt_d = ReqCount;
          if (req_no_shift) begin
            // A zero-length shift never needs the ALU; the operand is the answer.
            res_d   = ReqA;
            zero_d  = (ReqA == 8'h00);
            state_d = RESP;
          end else begin
            state_d = EXEC;
          end
        end
      end

      EXEC: begin
        if (exec_is_rsh) begin
          // Each pass shifts the accumulator by one; the ALU output becomes
          // the operand for the next pass.
          acc_d = AluOut;
          cnt_d = cnt_q - 3'd1;
          if (last_shift) begin
            res_d   = AluOut;
            zero_d  = AluZero;
            state_d = RESP;
          end
        end else begin
          res_d   = AluOut;
          zero_d  = AluZero;
          state_d = RESP;
        end
      end

      RESP: begin
        if (rsp_fire) begin
          op_count_d = op_count_q + 8'd1;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything so the ALU sees
  // all-zero inputs and any in-flight operation is dropped.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      op_q       <= 4'd0;
      acc_q      <= 8'd0;
      b_q        <= 8'd0;
      cnt_q      <= 3'd0;
      res_q      <= 8'd0;
      zero_q     <= 1'b0;
      op_count_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      b_q        <= b_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
      zero_q     <= zero_d;
      op_count_q <= op_count_d;
    end
  end

  // The ALU is driven straight from the registers; its output is only
  // consumed while executing.
  assign AluA  = acc_q;
  assign AluB  = b_q;
  assign AluOp = op_q;

  // Handshake and status outputs are pure decodes of the state register.
  assign ReqReady = (state_q == IDLE);
  assign RspValid = (state_q == RESP);
  assign Busy     = (state_q != IDLE);
  assign RspData  = res_q;
  assign RspZero  = zero_q;
  assign OpCount  = op_count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: a behavioural ALU closes the loop, a table of
// hand-computed vectors covers the named cases, hand-written sequences cover
// reset, shift iteration and backpressure, and random requests are checked
// against a reference model that computes results directly from operands.

module tb_alu_sequencer;
  import definitions::*;

  logic       Clk;
  logic       Reset;
  logic       ReqValid;
  logic       ReqReady;
  logic [3:0] ReqOp;
  logic [7:0] ReqA;
  logic [7:0] ReqB;
  logic [2:0] ReqCount;
  logic [7:0] AluA;
  logic [7:0] AluB;
  logic [3:0] AluOp;
  logic [7:0] AluOut;
  logic       AluZero;
  logic       RspValid;
  logic       RspReady;
  logic [7:0] RspData;
  logic       RspZero;
  logic       Busy;
  logic [7:0] OpCount;

  int         tests_run    = 0;
  int         tests_failed = 0;
  logic [7:0] exp_op_count = 8'd0;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] cnt;
    int         stall;
    logic [7:0] exp_data;
    logic       exp_zero;
    int         exp_lat;
  } vec_t;

  vec_t       vecs [15];
  logic [7:0] rsh_seq [3] = '{8'hB4, 8'h5A, 8'h2D};
  logic [3:0] valid_ops [7] = '{kADD, kR_XOR, kXOR, kAND, kRSH, SEQ, SLT};

  logic [3:0] r_op;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic [2:0] r_cnt;
  int         r_stall;
  int         r_idx;
  int         seen;

  alu_sequencer dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .ReqValid (ReqValid),
    .ReqReady (ReqReady),
    .ReqOp    (ReqOp),
    .ReqA     (ReqA),
    .ReqB     (ReqB),
    .ReqCount (ReqCount),
    .AluA     (AluA),
    .AluB     (AluB),
    .AluOp    (AluOp),
    .AluOut   (AluOut),
    .AluZero  (AluZero),
    .RspValid (RspValid),
    .RspReady (RspReady),
    .RspData  (RspData),
    .RspZero  (RspZero),
    .Busy     (Busy),
    .OpCount  (OpCount)
  );

  // Single-pass ALU behaviour; unknown opcodes produce zero.
  function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    case (op)
      kADD:    return a + b;
      kR_XOR:  return {7'd0, ^a};
      kXOR:    return a ^ b;
      kAND:    return a & b;
      kRSH:    return a >> 1;
      SEQ:     return (a == b) ? 8'd1 : 8'd0;
      SLT:     return (a < b) ? 8'd1 : 8'd0;
      default: return 8'd0;
    endcase
  endfunction

  // Whole-request result: shifts are taken by the full count in one step.
  function automatic logic [7:0] model_result(input logic [3:0] op, input logic [7:0] a,
                                              input logic [7:0] b, input logic [2:0] cnt);
    if (op == kRSH) return a >> cnt;
    return alu_fn(op, a, b);
  endfunction

  // Edges from accept to the response appearing.
  function automatic int model_latency(input logic [3:0] op, input logic [2:0] cnt);
    if (op == kRSH) return int'(cnt);
    return 1;
  endfunction

  // Combinational ALU attached to the sequencer.
  always_comb begin
    AluOut  = alu_fn(AluOp, AluA, AluB);
    AluZero = (AluOut == 8'h00);
  end

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyReset();
    @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    exp_op_count = 8'd0;
    @(negedge Clk);
  endtask

  // Issue one request, measure latency, hold off the response for 'stall'
  // cycles, then complete the handshake. Entered and left just after a negedge.
  task automatic applyStimulus(input string name, input logic [3:0] op, input logic [7:0] a,
                               input logic [7:0] b, input logic [2:0] cnt, input int stall,
                               input logic [7:0] exp_data, input logic exp_zero,
                               input int exp_lat);
    int lat;
    checkOutput({name, "_req_ready"}, ReqReady, 1);
    ReqValid = 1'b1;
    ReqOp    = op;
    ReqA     = a;
    ReqB     = b;
    ReqCount = cnt;
    @(posedge Clk);
    @(negedge Clk);
    ReqValid = 1'b0;
    ReqOp    = 4'($urandom);
    ReqA     = 8'($urandom);
    ReqB     = 8'($urandom);
    ReqCount = 3'($urandom);
    lat = 0;
    while (!RspValid && lat < 40) begin
      @(negedge Clk);
      lat++;
    end
    checkOutput({name, "_latency"}, lat, exp_lat);
    checkOutput({name, "_rsp_valid"}, RspValid, 1);
    if (!RspValid) return;
    checkOutput({name, "_data"}, RspData, exp_data);
    checkOutput({name, "_zero"}, RspZero, exp_zero);
    for (int s = 0; s < stall; s++) begin
      @(negedge Clk);
      checkOutput({name, "_stall_valid"}, RspValid, 1);
      checkOutput({name, "_stall_data"}, RspData, exp_data);
      checkOutput({name, "_stall_ready"}, ReqReady, 0);
    end
    RspReady = 1'b1;
    @(negedge Clk);
    RspReady = 1'b0;
    exp_op_count = exp_op_count + 8'd1;
    checkOutput({name, "_op_count"}, OpCount, exp_op_count);
    checkOutput({name, "_rsp_drop"}, RspValid, 0);
    checkOutput({name, "_idle"}, Busy, 0);
  endtask

  initial begin
    vecs[0]  = '{kADD,   8'hF0, 8'h10, 3'd0, 0, 8'h00, 1'b1, 1};
    vecs[1]  = '{kRSH,   8'hB4, 8'h00, 3'd3, 0, 8'h16, 1'b0, 3};
    vecs[2]  = '{kRSH,   8'h00, 8'h00, 3'd0, 0, 8'h00, 1'b1, 0};
    vecs[3]  = '{SLT,    8'h05, 8'h07, 3'd0, 0, 8'h01, 1'b0, 1};
    vecs[4]  = '{SEQ,    8'h3C, 8'h3C, 3'd0, 2, 8'h01, 1'b0, 1};
    vecs[5]  = '{kXOR,   8'hA5, 8'h5A, 3'd0, 0, 8'hFF, 1'b0, 1};
    vecs[6]  = '{kAND,   8'hF0, 8'h0F, 3'd0, 1, 8'h00, 1'b1, 1};
    vecs[7]  = '{kR_XOR, 8'h07, 8'h00, 3'd0, 0, 8'h01, 1'b0, 1};
    vecs[8]  = '{kRSH,   8'hFF, 8'h00, 3'd7, 0, 8'h01, 1'b0, 7};
    vecs[9]  = '{kRSH,   8'h80, 8'h00, 3'd1, 0, 8'h40, 1'b0, 1};
    vecs[10] = '{4'hF,   8'h12, 8'h34, 3'd5, 0, 8'h00, 1'b1, 1};
    vecs[11] = '{kRSH,   8'h5A, 8'h00, 3'd0, 3, 8'h5A, 1'b0, 0};
    vecs[12] = '{SLT,    8'h07, 8'h05, 3'd0, 0, 8'h00, 1'b1, 1};
    vecs[13] = '{kADD,   8'h7F, 8'h01, 3'd0, 0, 8'h80, 1'b0, 1};
    vecs[14] = '{kRSH,   8'h01, 8'h00, 3'd1, 0, 8'h00, 1'b1, 1};

    Reset    = 1'b0;
    ReqValid = 1'b0;
    ReqOp    = 4'd0;
    ReqA     = 8'd0;
    ReqB     = 8'd0;
    ReqCount = 3'd0;
    RspReady = 1'b0;
    repeat (2) @(negedge Clk);

    checkOutput("reset_rsp_valid", RspValid, 0);
    checkOutput("reset_req_ready", ReqReady, 1);
    checkOutput("reset_busy", Busy, 0);
    checkOutput("reset_rsp_data", RspData, 0);
    checkOutput("reset_rsp_zero", RspZero, 0);
    checkOutput("reset_op_count", OpCount, 0);
    checkOutput("reset_alu_a", AluA, 0);
    checkOutput("reset_alu_b", AluB, 0);
    checkOutput("reset_alu_op", AluOp, 0);
    Reset = 1'b1;
    @(negedge Clk);

    // Reset during the second shift pass must abort without a response.
    ReqValid = 1'b1;
    ReqOp    = kRSH;
    ReqA     = 8'hB4;
    ReqB     = 8'h00;
    ReqCount = 3'd5;
    @(posedge Clk);
    @(negedge Clk);
    ReqValid = 1'b0;
    @(negedge Clk);
    checkOutput("abort_busy_before", Busy, 1);
    checkOutput("abort_alu_a_before", AluA, 8'h5A);
    #2;
    Reset = 1'b0;
    #1;
    checkOutput("abort_rsp_valid", RspValid, 0);
    checkOutput("abort_req_ready", ReqReady, 1);
    checkOutput("abort_busy", Busy, 0);
    checkOutput("abort_op_count", OpCount, 0);
    @(negedge Clk);
    Reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      if (RspValid) seen++;
    end
    checkOutput("abort_no_response", seen, 0);
    checkOutput("abort_op_count_after", OpCount, 0);

    // Table of hand-computed vectors.
    for (int i = 0; i < 15; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cnt,
                    vecs[i].stall, vecs[i].exp_data, vecs[i].exp_zero, vecs[i].exp_lat);
    end

    // Watch the accumulator walk through each single-bit shift.
    ReqValid = 1'b1;
    ReqOp    = kRSH;
    ReqA     = 8'hB4;
    ReqB     = 8'h00;
    ReqCount = 3'd3;
    @(posedge Clk);
    @(negedge Clk);
    ReqValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rsh_seq_alu_a_%0d", i), AluA, rsh_seq[i]);
      checkOutput($sformatf("rsh_seq_alu_op_%0d", i), AluOp, kRSH);
      checkOutput($sformatf("rsh_seq_pending_%0d", i), RspValid, 0);
      @(negedge Clk);
    end
    checkOutput("rsh_seq_valid", RspValid, 1);
    checkOutput("rsh_seq_data", RspData, 8'h16);
    checkOutput("rsh_seq_zero", RspZero, 0);
    RspReady = 1'b1;
    @(negedge Clk);
    RspReady = 1'b0;
    exp_op_count = exp_op_count + 8'd1;
    checkOutput("rsh_seq_op_count", OpCount, exp_op_count);

    // Backpressure with an ignored request pulse and a request held across
    // the handshake edge.
    ReqValid = 1'b1;
    ReqOp    = SEQ;
    ReqA     = 8'h3C;
    ReqB     = 8'h3C;
    ReqCount = 3'd0;
    @(posedge Clk);
    @(negedge Clk);
    ReqValid = 1'b0;
    checkOutput("bp_exec_no_valid", RspValid, 0);
    @(negedge Clk);
    checkOutput("bp_valid", RspValid, 1);
    for (int s = 0; s < 4; s++) begin
      ReqValid = (s == 1);
      ReqOp    = kADD;
      ReqA     = 8'h11;
      ReqB     = 8'h22;
      @(negedge Clk);
      checkOutput($sformatf("bp_stall_valid_%0d", s), RspValid, 1);
      checkOutput($sformatf("bp_stall_data_%0d", s), RspData, 8'h01);
      checkOutput($sformatf("bp_stall_ready_%0d", s), ReqReady, 0);
    end
    RspReady = 1'b1;
    ReqValid = 1'b1;
    @(negedge Clk);
    RspReady = 1'b0;
    ReqValid = 1'b0;
    exp_op_count = exp_op_count + 8'd1;
    checkOutput("bp_op_count", OpCount, exp_op_count);
    checkOutput("bp_turnaround_busy", Busy, 0);
    checkOutput("bp_turnaround_ready", ReqReady, 1);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      if (RspValid || Busy) seen++;
    end
    checkOutput("bp_single_response", seen, 0);
    checkOutput("bp_op_count_after", OpCount, exp_op_count);

    // Randomized requests against the reference model.
    for (int i = 0; i < 80; i++) begin
      r_idx = $urandom_range(0, 8);
      if (r_idx < 7) r_op = valid_ops[r_idx];
      else r_op = 4'($urandom_range(7, 15));
      r_a     = 8'($urandom);
      r_b     = 8'($urandom);
      r_cnt   = 3'($urandom);
      r_stall = $urandom_range(0, 3);
      applyStimulus($sformatf("rnd%0d_op%0h", i, r_op), r_op, r_a, r_b, r_cnt, r_stall,
                    model_result(r_op, r_a, r_b, r_cnt),
                    (model_result(r_op, r_a, r_b, r_cnt) == 8'h00),
                    model_latency(r_op, r_cnt));
    end

    // OpCount wrap over 256 back-to-back handshakes from a fresh reset.
    applyReset();
    checkOutput("wrap_start", OpCount, 0);
    for (int i = 0; i < 256; i++) begin
      r_a = 8'($urandom);
      r_b = 8'($urandom);
      applyStimulus($sformatf("wrap%0d", i), kXOR, r_a, r_b, 3'd0, 0, r_a ^ r_b,
                    ((r_a ^ r_b) == 8'h00), 1);
      if (i == 254) checkOutput("wrap_255th", OpCount, 8'hFF);
    end
    checkOutput("wrap_256th", OpCount, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
